// File: rtl/fl_acc32.sv
// Sequential IEEE-754 single-precision accumulator: adds each accepted operand into acc
// through a fixed IDLE->ALIGN->ADD->NORM->PACK sequence, truncating toward zero.
module fl_acc32 #(
    parameter int LAT_STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] acc,
    output logic        acc_valid,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK} state_t;

    if (LAT_STAGES != 4) begin : g_lat_check
        $error("fl_acc32: LAT_STAGES is fixed at 4");
    end

    state_t             state;
    logic [31:0]        opb;
    logic               a_sign;
    logic [7:0]         a_exp;
    logic [23:0]        a_man;
    logic [23:0]        b_man;
    logic               eff_sub;
    logic               sp_nan;
    logic               sp_inf;
    logic               sp_inf_sign;
    logic [24:0]        sum;
    logic [23:0]        n_man;
    logic signed [9:0]  n_exp;
    logic               n_zero;

    // Unpack both operands; exponent 0 (zero or denormal) contributes a zero mantissa.
    logic [7:0]  x_exp, y_exp, la_exp, lb_exp, diff;
    logic [23:0] x_man, y_man, la_man, lb_man, b_shifted;
    logic        x_sign, y_sign, la_sign, lb_sign, swap;
    logic        x_nan, y_nan, x_inf, y_inf;

    always_comb begin
        x_sign = acc[31];
        x_exp  = acc[30:23];
        x_man  = (x_exp == 8'd0) ? 24'd0 : {1'b1, acc[22:0]};
        y_sign = opb[31];
        y_exp  = opb[30:23];
        y_man  = (y_exp == 8'd0) ? 24'd0 : {1'b1, opb[22:0]};
        x_nan  = (x_exp == 8'hFF) && (acc[22:0] != 23'd0);
        x_inf  = (x_exp == 8'hFF) && (acc[22:0] == 23'd0);
        y_nan  = (y_exp == 8'hFF) && (opb[22:0] != 23'd0);
        y_inf  = (y_exp == 8'hFF) && (opb[22:0] == 23'd0);
        swap   = (y_exp > x_exp) || ((y_exp == x_exp) && (y_man > x_man));
        la_sign = swap ? y_sign : x_sign;
        la_exp  = swap ? y_exp  : x_exp;
        la_man  = swap ? y_man  : x_man;
        lb_sign = swap ? x_sign : y_sign;
        lb_exp  = swap ? x_exp  : y_exp;
        lb_man  = swap ? x_man  : y_man;
        diff    = la_exp - lb_exp;
        b_shifted = (diff >= 8'd25) ? 24'd0 : (lb_man >> diff);
    end

    function automatic logic [4:0] lzc(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    logic [4:0]        lz;
    logic [23:0]       norm_man;
    logic signed [9:0] norm_exp;
    logic              norm_zero;

    always_comb begin
        lz        = lzc(sum[23:0]);
        norm_zero = (sum == 25'd0);
        if (sum[24]) begin
            norm_man = sum[24:1];
            norm_exp = $signed({2'b00, a_exp}) + 10'sd1;
        end else begin
            norm_man = sum[23:0] << lz;
            norm_exp = $signed({2'b00, a_exp}) - $signed({5'b00000, lz});
        end
    end

    // Specials take precedence over the datapath result, then range limits.
    logic [31:0] pack_res;

    always_comb begin
        if (sp_nan)
            pack_res = 32'h7FC00000;
        else if (sp_inf)
            pack_res = {sp_inf_sign, 8'hFF, 23'd0};
        else if (n_zero)
            pack_res = 32'h00000000;
        else if (n_exp >= 10'sd255)
            pack_res = {a_sign, 8'hFF, 23'd0};
        else if (n_exp <= 10'sd0)
            pack_res = 32'h00000000;
        else
            pack_res = {a_sign, n_exp[7:0], n_man[22:0]};
    end

    assign in_ready = (state == IDLE) && !clear;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= 32'd0;
            acc_valid   <= 1'b0;
            opb         <= 32'd0;
            a_sign      <= 1'b0;
            a_exp       <= 8'd0;
            a_man       <= 24'd0;
            b_man       <= 24'd0;
            eff_sub     <= 1'b0;
            sp_nan      <= 1'b0;
            sp_inf      <= 1'b0;
            sp_inf_sign <= 1'b0;
            sum         <= 25'd0;
            n_man       <= 24'd0;
            n_exp       <= 10'sd0;
            n_zero      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            acc       <= 32'd0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opb   <= in_data;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    a_sign      <= la_sign;
                    a_exp       <= la_exp;
                    a_man       <= la_man;
                    b_man       <= b_shifted;
                    eff_sub     <= la_sign ^ lb_sign;
                    sp_nan      <= x_nan || y_nan || (x_inf && y_inf && (x_sign != y_sign));
                    sp_inf      <= x_inf || y_inf;
                    sp_inf_sign <= x_inf ? x_sign : y_sign;
                    state       <= ADD;
                end
                ADD: begin
                    sum   <= eff_sub ? ({1'b0, a_man} - {1'b0, b_man})
                                     : ({1'b0, a_man} + {1'b0, b_man});
                    state <= NORM;
                end
                NORM: begin
                    n_man  <= norm_man;
                    n_exp  <= norm_exp;
                    n_zero <= norm_zero;
                    state  <= PACK;
                end
                PACK: begin
                    acc       <= pack_res;
                    acc_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
